// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Four-digit multiplexed seven-segment scan driver. It follows the one-hot
// phase word from a 4-bit ring counter and produces registered digit enables
// and segment data. Every phase change inserts BLANK_CYC dead cycles with all
// digits off, which suppresses ghosting. New display values arrive through a
// load/busy handshake and are only copied into the visible register at a frame
// boundary (an accepted change to phase 4'b1000), so a single frame never mixes
// two values. A phase word that is not one-hot latches a sticky fault.
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         synchronous active-high reset
//   phase[3:0]  one-hot digit select, bit i = digit i, 4'b1000 = frame start
//   load        one-cycle request to capture din
//   din[15:0]   four nibbles, din[4i+3:4i] is digit i
//   busy        pending value not yet transferred to the display
//   an[3:0]     registered digit enables, active-high
//   seg[6:0]    registered segments {g,f,e,d,c,b,a}, active-high
//   frame_start one-cycle pulse when a change to 4'b1000 is accepted
//   ovf         sticky: a load was dropped
//   err         sticky: illegal phase seen
//
// Parameter BLANK_CYC (0..15): dead-time cycles after each accepted phase change.
// Build option SEG_SCAN_HEX_EN: when defined, nibbles 10-15 show hex glyphs;
// when undefined they show a blank digit.

module seg_scan_driver #(
   parameter int BLANK_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  phase,
   input  logic        load,
   input  logic [15:0] din,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_start,
   output logic        ovf,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE, FAULT} state_t;

   localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYC);
   localparam bit         NO_BLANK   = (BLANK_CYC == 0);

   state_t      state, state_n;
   logic [3:0]  cur, cur_n;
   logic [3:0]  cnt, cnt_n;
   logic [15:0] display, display_n;
   logic [15:0] pending, pending_n;
   logic        busy_n, ovf_n, err_n, frame_start_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        phase_legal;
   logic        accept;
   logic        boundary;

   // Seven-segment glyphs; the letters only exist in the hex build.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'd0:    g = 7'h3F;
         4'd1:    g = 7'h06;
         4'd2:    g = 7'h5B;
         4'd3:    g = 7'h4F;
         4'd4:    g = 7'h66;
         4'd5:    g = 7'h6D;
         4'd6:    g = 7'h7D;
         4'd7:    g = 7'h07;
         4'd8:    g = 7'h7F;
         4'd9:    g = 7'h6F;
`ifdef SEG_SCAN_HEX_EN
         4'd10:   g = 7'h77;
         4'd11:   g = 7'h7C;
         4'd12:   g = 7'h39;
         4'd13:   g = 7'h5E;
         4'd14:   g = 7'h79;
         4'd15:   g = 7'h71;
`endif
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // Picks the nibble addressed by a one-hot digit select.
   function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [3:0] sel);
      logic [3:0] n;
      case (sel)
         4'b0001: n = v[3:0];
         4'b0010: n = v[7:4];
         4'b0100: n = v[11:8];
         default: n = v[15:12];
      endcase
      return n;
   endfunction

   assign phase_legal = (phase == 4'b0001) || (phase == 4'b0010) ||
                        (phase == 4'b0100) || (phase == 4'b1000);

   // Next-state and next-output logic. Digits are off unless the scan is in
   // DRIVE, so an and seg default to zero each cycle. A new phase restarts the
   // blanking count even when it arrives in the middle of BLANK. The load
   // handshake runs in every state; at a frame boundary the pending value moves
   // to the display and a load on that same edge refills pending without ovf.
   always_comb begin
      state_n       = state;
      cur_n         = cur;
      cnt_n         = cnt;
      display_n     = display;
      pending_n     = pending;
      busy_n        = busy;
      ovf_n         = ovf;
      err_n         = err;
      frame_start_n = 1'b0;
      an_n          = 4'b0000;
      seg_n         = 7'h00;
      accept        = 1'b0;
      boundary      = 1'b0;

      case (state)
         IDLE: begin
            if (phase != 4'b0000) begin
               if (phase_legal) begin
                  accept = 1'b1;
               end else begin
                  state_n = FAULT;
                  err_n   = 1'b1;
               end
            end
         end
         BLANK, DRIVE: begin
            if (!phase_legal) begin
               state_n = FAULT;
               err_n   = 1'b1;
            end else if (phase != cur) begin
               accept = 1'b1;
            end else if (state == BLANK) begin
               if (cnt <= 4'd1) begin
                  state_n = DRIVE;
                  cnt_n   = 4'd0;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end else begin
               an_n  = cur;
               seg_n = decode(pick_nibble(display, cur));
            end
         end
         default: begin
            state_n = FAULT;
            err_n   = 1'b1;
         end
      endcase

      if (accept) begin
         cur_n         = phase;
         cnt_n         = BLANK_INIT;
         state_n       = NO_BLANK ? DRIVE : BLANK;
         boundary      = (phase == 4'b1000);
         frame_start_n = boundary;
      end

      if (boundary && busy) begin
         display_n = pending;
         if (load) begin
            pending_n = din;
         end else begin
            busy_n = 1'b0;
         end
      end else if (load) begin
         if (!busy) begin
            pending_n = din;
            busy_n    = 1'b1;
         end else begin
            ovf_n = 1'b1;
         end
      end

      // With no dead time the new digit lights on the very edge the change is
      // accepted, using the display value that edge produces.
      if (accept && NO_BLANK) begin
         an_n  = phase;
         seg_n = decode(pick_nibble(display_n, phase));
      end
   end

   // State and output registers; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cur         <= 4'b0000;
         cnt         <= 4'd0;
         display     <= 16'h0000;
         pending     <= 16'h0000;
         busy        <= 1'b0;
         ovf         <= 1'b0;
         err         <= 1'b0;
         frame_start <= 1'b0;
         an          <= 4'b0000;
         seg         <= 7'h00;
      end else begin
         state       <= state_n;
         cur         <= cur_n;
         cnt         <= cnt_n;
         display     <= display_n;
         pending     <= pending_n;
         busy        <= busy_n;
         ovf         <= ovf_n;
         err         <= err_n;
         frame_start <= frame_start_n;
         an          <= an_n;
         seg         <= seg_n;
      end
   end

endmodule
